// File: rtl/leiwand_rv32_uart_rx_if.sv
// Valid/ready memory-mapped bus used by leiwand_rv32 peripherals.
// The CPU side drives requests (master) and the peripheral answers them (slave).
interface leiwand_rv32_uart_rx_if #(
  parameter int unsigned XLEN = 32
);
  logic              valid;
  logic              ready;
  logic [XLEN/8-1:0] wen;
  logic [XLEN-1:0]   addr;
  logic [XLEN-1:0]   wdata;
  logic [XLEN-1:0]   rdata;

  modport master (output valid, wen, addr, wdata, input ready, rdata);
  modport slave  (input valid, wen, addr, wdata, output ready, rdata);
endinterface

// File: rtl/leiwand_rv32_uart_rx.sv
// 8N1 UART receiver with a bus-readable byte buffer (RXD 0x08, STATUS 0x0C).
// Defining LEIWAND_UART_RX_FIFO_EN selects a FIFO_DEPTH-entry FIFO instead of one holding register.
module leiwand_rv32_uart_rx #(
  parameter int unsigned CLK_DIV    = 868,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  leiwand_rv32_uart_rx_if.slave  bus,
  input  logic                   rxd,
  output logic                   irq
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam logic [15:0] DIV_FULL = 16'(CLK_DIV);
  localparam logic [15:0] DIV_HALF = 16'(CLK_DIV / 2);

  logic        rx_meta, rxs, rxs_prev;
  logic [1:0]  state;
  logic [15:0] cnt;
  logic [2:0]  bitn;
  logic [7:0]  shreg;
  logic        cnt_exp, push, frame_bad, do_push;

  logic        avail, full, overrun, frame_err;
  logic [7:0]  head;

  logic        accept, is_rd, hit_rxd, hit_st, pop, clr_ov, clr_fe;
  logic [31:0] rd_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta  <= 1'b1;
      rxs      <= 1'b1;
      rxs_prev <= 1'b1;
    end else begin
      rx_meta  <= rxd;
      rxs      <= rx_meta;
      rxs_prev <= rxs;
    end
  end

  assign cnt_exp   = (cnt == 16'd1);
  assign push      = (state == S_STOP) && cnt_exp && rxs;
  assign frame_bad = (state == S_STOP) && cnt_exp && !rxs;

  // Start only on a seen 1->0 edge, so a line held low after a frame cannot re-trigger.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      bitn  <= '0;
      shreg <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (rxs_prev && !rxs) begin
            state <= S_START;
            cnt   <= DIV_HALF;
          end
        end
        S_START: begin
          if (cnt_exp) begin
            state <= rxs ? S_IDLE : S_DATA;
            cnt   <= DIV_FULL;
            bitn  <= '0;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        S_DATA: begin
          if (cnt_exp) begin
            shreg <= {rxs, shreg[7:1]};
            cnt   <= DIV_FULL;
            if (bitn == 3'd7) state <= S_STOP;
            else              bitn  <= bitn + 3'd1;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        default: begin
          if (cnt_exp) state <= S_IDLE;
          else         cnt   <= cnt - 16'd1;
        end
      endcase
    end
  end

  // A same-cycle pop frees a slot before the push is considered.
  assign do_push = push && (!full || pop);

`ifdef LEIWAND_UART_RX_FIFO_EN
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wptr, rptr, count;

  assign count = wptr - rptr;
  assign avail = (wptr != rptr);
  assign full  = (count == (AW+1)'(FIFO_DEPTH));
  assign head  = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (pop)     rptr <= rptr + 1'b1;
      if (do_push) wptr <= wptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= shreg;
  end
`else
  logic [7:0] hold;
  logic       hold_v;

  assign avail = hold_v;
  assign full  = hold_v;
  assign head  = hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold   <= '0;
      hold_v <= 1'b0;
    end else if (do_push) begin
      hold   <= shreg;
      hold_v <= 1'b1;
    end else if (pop) begin
      hold_v <= 1'b0;
    end
  end
`endif

  assign accept  = bus.valid && !bus.ready;
  assign is_rd   = (bus.wen == '0);
  assign hit_rxd = (bus.addr[15:0] == 16'h0008);
  assign hit_st  = (bus.addr[15:0] == 16'h000C);
  assign pop     = accept && is_rd && hit_rxd && avail;
  assign clr_ov  = accept && !is_rd && hit_st && bus.wen[0] && bus.wdata[1];
  assign clr_fe  = accept && !is_rd && hit_st && bus.wen[0] && bus.wdata[2];

  always_comb begin
    rd_next = '0;
    if (is_rd && hit_rxd && avail) rd_next = {24'h0, head};
    if (is_rd && hit_st)           rd_next = {28'h0, full, frame_err, overrun, avail};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.ready <= 1'b0;
      bus.rdata <= '0;
      irq       <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      bus.ready <= bus.valid;
      if (accept) bus.rdata <= rd_next;
      irq       <= avail;
      overrun   <= (overrun & ~clr_ov) | (push & full & ~pop);
      frame_err <= (frame_err & ~clr_fe) | frame_bad;
    end
  end

  logic unused;
  assign unused = ^{bus.addr[31:16], bus.wdata[31:3], bus.wdata[0], bus.wen[3:1], 32'(FIFO_DEPTH)};

endmodule

// File: tb/tb_leiwand_rv32_uart_rx.sv
// Self-checking bench for leiwand_rv32_uart_rx: directed scenarios plus random frames vs a queue model.
// Honours LEIWAND_UART_RX_FIFO_EN to size the model buffer.
module tb_leiwand_rv32_uart_rx;

  localparam int unsigned DIV = 16;
`ifdef LEIWAND_UART_RX_FIFO_EN
  localparam int unsigned D = 8;
`else
  localparam int unsigned D = 1;
`endif

  localparam logic [31:0] A_RXD = 32'h0000_0008;
  localparam logic [31:0] A_ST  = 32'h0000_000C;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rxd = 1'b1;
  logic irq;

  leiwand_rv32_uart_rx_if #(.XLEN(32)) bus_if ();

  leiwand_rv32_uart_rx #(.CLK_DIV(DIV), .FIFO_DEPTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if),
    .rxd (rxd),
    .irq (irq)
  );

  always #5 clk = ~clk;

  int unsigned tests = 0;
  int unsigned fails = 0;

  logic [7:0] q[$];
  logic       m_ov = 1'b0;
  logic       m_fe = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_status();
    return {28'h0, q.size() == D, m_fe, m_ov, q.size() != 0};
  endfunction

  task automatic model_frame(input logic [7:0] b, input logic ok);
    if (!ok)               m_fe = 1'b1;
    else if (q.size() == D) m_ov = 1'b1;
    else                   q.push_back(b);
  endtask

  function automatic logic [31:0] model_pop();
    if (q.size() == 0) return 32'h0;
    return {24'h0, q.pop_front()};
  endfunction

  task automatic model_reset();
    q.delete();
    m_ov = 1'b0;
    m_fe = 1'b0;
  endtask

  // Called at a negedge; ends at a negedge two idle cycles after the stop bit.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int unsigned i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (DIV) @(negedge clk);
    end
    rxd = stop;
    repeat (DIV) @(negedge clk);
    rxd = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic bus_xfer(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd,
                          output logic [31:0] rd);
    @(negedge clk);
    bus_if.valid = 1'b1;
    bus_if.addr  = a;
    bus_if.wen   = we;
    bus_if.wdata = wd;
    @(negedge clk);
    rd = bus_if.rdata;
    bus_if.valid = 1'b0;
    bus_if.wen   = 4'h0;
    @(negedge clk);
  endtask

  task automatic chk_status(input string tag);
    logic [31:0] rd;
    bus_xfer(A_ST, 4'h0, 32'h0, rd);
    check(tag, rd, m_status());
  endtask

  task automatic chk_rxd(input string tag);
    logic [31:0] rd;
    logic [31:0] e;
    e = model_pop();
    bus_xfer(A_RXD, 4'h0, 32'h0, rd);
    check(tag, rd, e);
  endtask

  task automatic w1c(input logic [31:0] wd);
    logic [31:0] rd;
    bus_xfer(A_ST, 4'h1, wd, rd);
    if (wd[1]) m_ov = 1'b0;
    if (wd[2]) m_fe = 1'b0;
  endtask

  logic [31:0] rd;
  logic [31:0] e_read;
  logic [7:0]  nb;

  initial begin
    bus_if.valid = 1'b0;
    bus_if.wen   = 4'h0;
    bus_if.addr  = '0;
    bus_if.wdata = '0;
    repeat (3) @(negedge clk);
    check("reset_ready", {31'h0, bus_if.ready}, 32'h0);
    check("reset_rdata", bus_if.rdata, 32'h0);
    check("reset_irq", {31'h0, irq}, 32'h0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk_status("reset_status");

    // Basic frame
    send_frame(8'h55, 1'b1);
    model_frame(8'h55, 1'b1);
    chk_status("rx55_status");
    check("rx55_irq", {31'h0, irq}, 32'h1);
    chk_rxd("rx55_data");
    chk_status("rx55_status_after");
    check("rx55_irq_after", {31'h0, irq}, 32'h0);

    // Short glitch is not a start bit
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    repeat (40) @(negedge clk);
    chk_status("glitch_status");

    // Framing error
    send_frame(8'hA3, 1'b0);
    model_frame(8'hA3, 1'b0);
    chk_status("ferr_status");
    chk_rxd("ferr_rxd_empty");
    w1c(32'h4);
    chk_status("ferr_cleared");

    // Overflow: one more byte than the buffer holds
    for (int unsigned i = 0; i <= D; i++) begin
      nb = (D == 1) ? ((i == 0) ? 8'h11 : 8'h22) : 8'(i + 1);
      send_frame(nb, 1'b1);
      model_frame(nb, 1'b1);
    end
    chk_status("ovf_status");
    for (int unsigned i = 0; i < D; i++) chk_rxd("ovf_data");
    chk_status("ovf_status_drained");
    w1c(32'h2);
    chk_status("ovf_cleared");

    // Full buffer; RXD accept edge lands on the stop-bit push edge
    for (int unsigned i = 0; i < D; i++) begin
      nb = 8'($urandom);
      send_frame(nb, 1'b1);
      model_frame(nb, 1'b1);
    end
    nb = 8'($urandom);
    e_read = {24'h0, q[0]};
    fork
      send_frame(nb, 1'b1);
      begin
        repeat (9 * DIV + DIV / 2 + 1) @(negedge clk);
        bus_xfer(A_RXD, 4'h0, 32'h0, rd);
      end
    join
    check("coinc_pop_data", rd, e_read);
    void'(model_pop());
    model_frame(nb, 1'b1);
    chk_status("coinc_status");
    for (int unsigned i = 0; i < D; i++) chk_rxd("coinc_drain");
    chk_status("coinc_empty");

    // Random frames, reads, flag clears and stray accesses
    for (int unsigned it = 0; it < 6; it++) begin
      int unsigned n;
      n = $urandom_range(1, D + 1);
      for (int unsigned k = 0; k < n; k++) begin
        logic ok;
        nb = 8'($urandom);
        ok = ($urandom_range(0, 5) != 0);
        send_frame(nb, ok);
        model_frame(nb, ok);
      end
      chk_status("rnd_status");
      check("rnd_irq", {31'h0, irq}, {31'h0, q.size() != 0});
      bus_xfer(A_RXD, 4'hF, $urandom, rd);
      check("rnd_wr_rxd_rdata", rd, 32'h0);
      bus_xfer({$urandom_range(0, 65535), 16'h0010 + 16'(4 * $urandom_range(0, 8))}, 4'h0, 32'h0, rd);
      check("rnd_unmapped_rdata", rd, 32'h0);
      n = $urandom_range(0, D + 1);
      for (int unsigned k = 0; k < n; k++) chk_rxd("rnd_data");
      w1c({29'h0, 2'($urandom), 1'b0});
      chk_status("rnd_status_w1c");
    end
    while (q.size() != 0) chk_rxd("rnd_final_drain");
    w1c(32'h6);
    chk_status("rnd_final_status");

    // Reset during the data bits of 0x7E
    rxd = 1'b0;
    repeat (DIV) @(negedge clk);
    nb = 8'h7E;
    for (int unsigned i = 0; i < 4; i++) begin
      rxd = nb[i];
      repeat (DIV) @(negedge clk);
    end
    rst = 1'b1;
    rxd = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4 * DIV) @(negedge clk);
    chk_status("midrst_status");
    send_frame(8'h3C, 1'b1);
    model_frame(8'h3C, 1'b1);
    chk_status("midrst_rx_status");
    chk_rxd("midrst_data");
    chk_status("midrst_final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/leiwand_rv32_uart_rx.md
# leiwand_rv32_uart_rx

Serial UART receiver peripheral for leiwand_rv32, the receive counterpart to the existing simulation-only transmit UART. Deserialises 8N1 frames from an external `rxd` pin, buffers received bytes, and exposes them to the CPU through the same valid/ready memory-mapped bus slave interface used by the other peripherals. Data and status registers occupy the RXD slot of the UART address window.

## Interface
Parameters:
- `CLK_DIV`, 868: clock cycles per bit (100 MHz / 115200). Legal range 4..65535.
- `FIFO_DEPTH`, 8: entries when `LEIWAND_UART_RX_FIFO_EN` is defined; must be a power of two.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `valid`  in  1  bus request.
- `ready`  out  1  bus acknowledge.
- `wen`  in  `XLEN/8`  byte write enables; all-zero means read.
- `addr`  in  `XLEN`  byte address; only `addr[15:0]` decoded.
- `wdata`  in  `XLEN`  write data.
- `rdata`  out  `XLEN`  read data.
- `rxd`  in  1  asynchronous serial input, idle high.
- `irq`  out  1  level high while receive data is available.

## Operation
- Register map (`addr[15:0]`): 0x0008 RXD (read-only): `{24'h0, byte}`; a read pops one entry if non-empty, returns 0 and pops nothing if empty. 0x000C STATUS: bit0 `avail` (non-empty), bit1 `overrun` (sticky), bit2 `frame_err` (sticky), bit3 `full`, other bits 0. Write with `wen[0]`=1: `wdata[1]`/`wdata[2]` = 1 clears the matching sticky bit (W1C). Writes to RXD and all unmapped accesses: no side effect, `rdata` = 0.
- `rxd` passes through a 2-flop synchroniser (reset value 1); the FSM uses only the synchronised value `rxs`.
- FSM: IDLE -> START on a 1->0 transition of `rxs`, bit counter loaded with `CLK_DIV/2` (floor). START: at counter expiry, `rxs`=0 -> DATA (counter = `CLK_DIV`); `rxs`=1 -> IDLE (glitch, nothing recorded). DATA: sample every `CLK_DIV` cycles, 8 bits, LSB first. STOP: sample after `CLK_DIV` cycles; `rxs`=1 -> push byte; `rxs`=0 -> set `frame_err`, discard byte. STOP always returns to IDLE, which re-arms only after `rxs` has been seen high (no false start during a break).
- Push when full: byte dropped, existing contents kept, `overrun` set.
- Pop and push in the same cycle: pop is applied first, push succeeds, no overrun even if previously full; `avail` stays 1.
- Pop and W1C are only executed in the accept cycle (see Timing).
- `irq` = `avail`, registered.

## Timing
- Reset values: `ready`=0, `rdata`=0, `irq`=0, FSM IDLE, buffer empty, `overrun`=`frame_err`=0, synchroniser flops 1. Reset mid-frame aborts the frame with no push and no error flag.
- Bus: `ready` is registered as `valid` (1 cycle after `valid` rises; low 1 cycle after `valid` falls). Accept cycle = `valid`=1 and `ready`=0; `rdata` is loaded and side effects occur at that edge. One access per `valid` high period; holding `valid` does not pop again.
- Receive latency: byte pushed at the stop-bit sample edge; `avail`/`irq` high on the next edge. First data sample at 1.5 bit times after start edge, plus 2 synchroniser cycles.
- Counter width 16 bits; counter counts down to 1, no wrap-around dependency.

## Configuration
- `LEIWAND_UART_RX_FIFO_EN` defined: circular buffer of `FIFO_DEPTH` entries, pointers one bit wider than log2(`FIFO_DEPTH`) for full/empty; `full` when count = `FIFO_DEPTH`.
- Undefined: single holding register (depth 1); `full` = `avail`; `FIFO_DEPTH` ignored. Register map and flag semantics identical.

## Test plan
- `CLK_DIV`=16, send frame 0x55 -> STATUS reads 0x1, `irq`=1; RXD reads 0x00000055; STATUS then 0x0, `irq`=0.
- Pull `rxd` low for 4 cycles then high -> no push, STATUS stays 0x0.
- Send 0xA3 with stop bit 0 -> STATUS 0x4, RXD reads 0; write STATUS `wdata`=0x4 -> STATUS 0x0.
- FIFO enabled: send 0x01..0x09 without reading -> STATUS 0xB; eight RXD reads return 0x01..0x08, then STATUS 0x2. FIFO disabled: send 0x11, 0x22 -> RXD returns 0x11, `overrun` set.
- Buffer full, RXD read accept cycle coincides with stop-bit push -> no overrun, new byte retained last.
- Assert `rst` during DATA bits of 0x7E, release, send 0x3C -> only 0x3C received, STATUS flags clear.
